// File: rtl/seq_detect_pkg.sv
// Shared constants and helper functions for the parametrised serial pattern detector.
package seq_detect_pkg;

  localparam logic [3:0] RST_PAT4    = 4'b1010;
  localparam int         RST_PAT_LEN = 4;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Lengths below 1 become 1; lengths above the history depth become the depth.
  function automatic int clamp_len(input int req, input int max_len);
    if (req < 1) return 1;
    if (req > max_len) return max_len;
    return req;
  endfunction

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter with synchronous clear; the clear wins over an increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Serial bit-pattern detector with runtime-loadable pattern, selectable overlap and match counter.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int                 MAX_LEN     = 8,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(RST_PAT4),
  parameter int                 RST_LEN     = RST_PAT_LEN,
  parameter int                 CNT_W       = 16,
  localparam int                LW          = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               input_bit,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               count_clr,
  output logic               output_detected,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy_fill
);

  logic [MAX_LEN-1:0] history;
  logic [MAX_LEN-1:0] pattern;
  logic [MAX_LEN-1:0] hist_shift;
  logic [MAX_LEN-1:0] mask;
  logic [LW-1:0]      len;
  logic [LW-1:0]      fill;
  logic [LW-1:0]      len_nxt;
  logic [LW-1:0]      fill_nxt;
  logic               overlap;
  logic               match;

  always_comb begin
    hist_shift = {history[MAX_LEN-2:0], input_bit};
    mask       = ~({MAX_LEN{1'b1}} << len);
    // The oldest history bit falls off the shift; it is masked out of the compare anyway.
    match      = in_valid && !cfg_load
                 && (({history, input_bit} & {1'b0, mask}) == {1'b0, pattern & mask})
                 && (({1'b0, fill} + (LW+1)'(1)) >= {1'b0, len});
    len_nxt    = len;
    fill_nxt   = fill;
    if (cfg_load) begin
      len_nxt  = LW'(clamp_len(int'(cfg_len), MAX_LEN));
      fill_nxt = '0;
    end else if (match) begin
      fill_nxt = overlap ? len : '0;
    end else if (in_valid && (fill < len)) begin
      fill_nxt = fill + LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      history         <= '0;
      fill            <= '0;
      pattern         <= RST_PATTERN;
      len             <= LW'(RST_LEN);
      overlap         <= 1'b1;
      output_detected <= 1'b0;
      busy_fill       <= 1'b1;
    end else begin
      fill            <= fill_nxt;
      len             <= len_nxt;
      output_detected <= match;
      busy_fill       <= (fill_nxt < len_nxt);
      if (cfg_load) begin
        pattern <= cfg_pattern;
        overlap <= cfg_overlap;
        history <= '0;
      end else if (in_valid) begin
        history <= hist_shift;
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_count (
    .clk   (clk),
    .reset (reset),
    .inc   (match),
    .clr   (count_clr),
    .count (match_count)
  );

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: directed scenarios plus a randomized stream against a queue-based model.
module tb_seq_detect_param;

  localparam int MAXL = 8;

  logic       clk = 1'b0;
  logic       reset, in_valid, input_bit, cfg_load, cfg_overlap, count_clr;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       det, busy, det_s, busy_s;
  logic [15:0] cnt;
  logic [1:0]  cnt_s;

  int n_chk  = 0;
  int n_fail = 0;

  bit         mq[$];
  logic [7:0] m_pat;
  int         m_len, m_cnt, m_cnt2;
  bit         m_ovl, m_det, m_busy;
  logic [21:0] exp_v;
  wire  [21:0] obs = {det, busy, cnt, det_s, busy_s, cnt_s};

  always #5 clk = ~clk;

  seq_detect_param dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .input_bit(input_bit),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .count_clr(count_clr),
    .output_detected(det), .match_count(cnt), .busy_fill(busy)
  );

  seq_detect_param #(.CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .input_bit(input_bit),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .count_clr(count_clr),
    .output_detected(det_s), .match_count(cnt_s), .busy_fill(busy_s)
  );

  // One clock: apply inputs, advance the reference model at the edge, settle.
  task automatic cycle(input bit v, input bit b, input bit ld, input bit clr, input bit rst);
    bit hit;
    int l;
    in_valid = v; input_bit = b; cfg_load = ld; count_clr = clr; reset = rst;
    @(posedge clk);
    m_det = 0;
    if (rst) begin
      mq.delete(); m_pat = 8'b0000_1010; m_len = 4; m_ovl = 1; m_cnt = 0; m_cnt2 = 0;
    end else begin
      if (ld) begin
        l = int'(cfg_len);
        if (l < 1) l = 1;
        if (l > MAXL) l = MAXL;
        m_pat = cfg_pattern; m_len = l; m_ovl = cfg_overlap; mq.delete();
      end else if (v) begin
        mq.push_back(b);
        if (mq.size() > m_len) void'(mq.pop_front());
        if (mq.size() == m_len) begin
          hit = 1;
          for (int i = 0; i < m_len; i++) if (mq[i] != m_pat[m_len-1-i]) hit = 0;
          if (hit) begin
            m_det = 1;
            if (!m_ovl) mq.delete();
          end
        end
      end
      if (clr) begin
        m_cnt = 0; m_cnt2 = 0;
      end else if (m_det) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
    m_busy = (mq.size() < m_len);
    exp_v = {m_det, m_busy, 16'(m_cnt), m_det, m_busy, 2'(m_cnt2)};
    #1;
    in_valid = 0; cfg_load = 0; count_clr = 0; reset = 0; input_bit = 1'($urandom);
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input bit o);
    cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    cycle(0, 0, 1, 0, 0);
    n_chk++; if (obs !== exp_v) begin n_fail++; $display("FAIL load: obs=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_reset();
    cycle(0, 0, 0, 0, 1);
    cycle(1, 1, 0, 0, 1);
    n_chk++; if ({det, busy, cnt} !== {1'b0, 1'b1, 16'd0}) begin
      n_fail++; $display("FAIL reset_values: got det=%b busy=%b cnt=%0d want 0 1 0", det, busy, cnt);
    end
    n_chk++; if (obs !== exp_v) begin n_fail++; $display("FAIL reset_model: obs=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_basic();
    bit [3:0] s = 4'b1010;
    cycle(0, 0, 0, 0, 1);
    for (int i = 3; i >= 0; i--) begin
      cycle(1, s[i], 0, 0, 0);
      n_chk++; if (obs !== exp_v) begin n_fail++; $display("FAIL basic: obs=%h exp=%h", obs, exp_v); end
      n_chk++; if (det !== (i == 0)) begin n_fail++; $display("FAIL basic_pulse bit%0d: got %b want %b", 3-i, det, i == 0); end
    end
    n_chk++; if (cnt !== 16'd1) begin n_fail++; $display("FAIL basic_count: got %0d want 1", cnt); end
  endtask

  task automatic test_overlap_default();
    bit [5:0] s = 6'b101010;
    int pulses = 0;
    cycle(0, 0, 0, 0, 1);
    for (int i = 5; i >= 0; i--) begin
      cycle(1, s[i], 0, 0, 0);
      pulses += int'(det);
      n_chk++; if (obs !== exp_v) begin n_fail++; $display("FAIL ovl_default: obs=%h exp=%h", obs, exp_v); end
    end
    n_chk++; if (pulses != 2 || cnt !== 16'd2) begin
      n_fail++; $display("FAIL ovl_default_count: pulses=%0d cnt=%0d want 2 2", pulses, cnt);
    end
  endtask

  task automatic test_nonoverlap();
    bit [7:0] s = 8'b11011010;
    bit [7:0] seen = '0;
    cycle(0, 0, 0, 0, 1);
    load(8'b110, 4'd3, 0);
    for (int i = 0; i < 8; i++) begin
      cycle(1, s[7-i], 0, 0, 0);
      seen[i] = det;
      n_chk++; if (obs !== exp_v) begin n_fail++; $display("FAIL nonovl: obs=%h exp=%h", obs, exp_v); end
    end
    n_chk++; if (seen !== 8'b0010_0100) begin n_fail++; $display("FAIL nonovl_positions: got %b want 00100100", seen); end
  endtask

  task automatic test_overlap_cmp();
    for (int o = 0; o < 2; o++) begin
      int pulses = 0;
      cycle(0, 0, 0, 0, 1);
      load(8'b11, 4'd2, o[0]);
      for (int i = 0; i < 4; i++) begin
        cycle(1, 1, 0, 0, 0);
        pulses += int'(det);
        n_chk++; if (obs !== exp_v) begin n_fail++; $display("FAIL ovl_cmp: obs=%h exp=%h", obs, exp_v); end
      end
      n_chk++; if (pulses != (o ? 3 : 2)) begin
        n_fail++; $display("FAIL ovl_cmp_pulses ovl=%0d: got %0d want %0d", o, pulses, o ? 3 : 2);
      end
    end
  endtask

  task automatic test_gaps();
    bit [3:0] s = 4'b1010;
    int pulses = 0;
    cycle(0, 0, 0, 0, 1);
    for (int i = 3; i >= 0; i--) begin
      cycle(1, s[i], 0, 0, 0);
      pulses += int'(det);
      n_chk++; if (det !== (i == 0)) begin n_fail++; $display("FAIL gaps_pulse bit%0d: got %b want %b", 3-i, det, i == 0); end
      for (int g = 0; g < 1 + int'($urandom_range(0, 2)); g++) begin
        cycle(0, 1'($urandom), 0, 0, 0);
        pulses += int'(det);
        n_chk++; if (obs !== exp_v) begin n_fail++; $display("FAIL gaps: obs=%h exp=%h", obs, exp_v); end
      end
    end
    n_chk++; if (pulses != 1) begin n_fail++; $display("FAIL gaps_count: got %0d want 1", pulses); end
  endtask

  task automatic test_saturate();
    cycle(0, 0, 0, 0, 1);
    load(8'b1, 4'd1, 1);
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, 0);
    n_chk++; if (cnt_s !== 2'd3 || cnt !== 16'd5) begin
      n_fail++; $display("FAIL saturate: got cnt_s=%0d cnt=%0d want 3 5", cnt_s, cnt);
    end
  endtask

  task automatic test_clr_same();
    cycle(0, 0, 0, 0, 1);
    cycle(1, 1, 0, 0, 0); cycle(1, 0, 0, 0, 0); cycle(1, 1, 0, 0, 0);
    cycle(1, 0, 0, 1, 0);
    n_chk++; if ({det, cnt, cnt_s} !== {1'b1, 16'd0, 2'd0}) begin
      n_fail++; $display("FAIL clr_same: got det=%b cnt=%0d want det=1 cnt=0", det, cnt);
    end
  endtask

  task automatic test_load_mid();
    cycle(0, 0, 0, 0, 1);
    cycle(1, 1, 0, 0, 0); cycle(1, 0, 0, 0, 0); cycle(1, 1, 0, 0, 0);
    cfg_pattern = 8'b1010; cfg_len = 4'd4; cfg_overlap = 1;
    cycle(1, 1, 1, 0, 0);
    cycle(1, 0, 0, 0, 0);
    n_chk++; if ({det, busy} !== 2'b01) begin n_fail++; $display("FAIL load_mid: got det=%b busy=%b want 0 1", det, busy); end
  endtask

  task automatic test_reset_mid();
    cycle(0, 0, 0, 0, 1);
    load(8'b11, 4'd2, 0);
    cycle(1, 1, 0, 0, 0); cycle(1, 1, 0, 0, 0); cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 1);
    n_chk++; if ({det, busy, cnt} !== {1'b0, 1'b1, 16'd0}) begin
      n_fail++; $display("FAIL reset_mid: got det=%b busy=%b cnt=%0d want 0 1 0", det, busy, cnt);
    end
    cycle(1, 0, 0, 0, 0);
    n_chk++; if (det !== 1'b0) begin n_fail++; $display("FAIL reset_mid_pulse: got %b want 0", det); end
  endtask

  task automatic test_len_clamp();
    bit [2:0] s = 3'b101;
    cycle(0, 0, 0, 0, 1);
    load(8'b1, 4'd0, 1);
    for (int i = 2; i >= 0; i--) begin
      cycle(1, s[i], 0, 0, 0);
      n_chk++; if ({det, busy} !== {s[i], 1'b0}) begin
        n_fail++; $display("FAIL len0 bit%0d: got det=%b busy=%b want %b 0", 2-i, det, busy, s[i]);
      end
    end
    load(8'hFF, 4'd12, 1);
    for (int i = 0; i < 8; i++) begin
      cycle(1, 1, 0, 0, 0);
      n_chk++; if ({det, busy} !== {i == 7, i != 7}) begin
        n_fail++; $display("FAIL len12 bit%0d: got det=%b busy=%b want %b %b", i, det, busy, i == 7, i != 7);
      end
    end
  endtask

  task automatic test_random();
    cycle(0, 0, 0, 0, 1);
    for (int n = 0; n < 1500; n++) begin
      bit ld, clr, rst;
      ld  = ($urandom_range(0, 39) == 0);
      clr = ($urandom_range(0, 59) == 0);
      rst = ($urandom_range(0, 299) == 0);
      if (ld) begin
        cfg_pattern = 8'($urandom);
        cfg_len     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 4));
        cfg_overlap = 1'($urandom);
      end
      cycle($urandom_range(0, 3) != 0, 1'($urandom), ld, clr, rst);
      n_chk++; if (obs !== exp_v) begin n_fail++; $display("FAIL random cyc%0d: obs=%h exp=%h", n, obs, exp_v); end
    end
  endtask

  initial begin
    reset = 1; in_valid = 0; input_bit = 0; cfg_load = 0; count_clr = 0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0;
    test_reset();
    test_basic();
    test_overlap_default();
    test_nonoverlap();
    test_overlap_cmp();
    test_gaps();
    test_saturate();
    test_clr_same();
    test_load_mid();
    test_reset_mid();
    test_len_clamp();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial bit-pattern detector, the successor to the fixed 4-bit FSM detector. It watches a one-bit stream qualified by a valid strobe and matches it against a runtime-loadable pattern of up to MAX_LEN bits. Overlapping or non-overlapping matching is selectable, and a saturating match counter is kept. It sits between the serial front end and the event/status logic and emits one registered pulse per match.

## Interface
Parameters:
- MAX_LEN, 8: maximum pattern length in bits (≥2).
- RST_PATTERN, 8'b0000_1010: pattern loaded at reset, right-aligned.
- RST_LEN, 4: pattern length at reset (reset config detects 1,0,1,0).
- CNT_W, 16: match counter width.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high; all state cleared on the clk edge where it is high.
- in_valid  in  1  input_bit is sampled only when high.
- input_bit  in  1  serial data bit.
- cfg_load  in  1  one-cycle strobe to adopt the cfg_* values.
- cfg_pattern  in  MAX_LEN  new pattern, right-aligned; bit [len-1] is the first bit expected.
- cfg_len  in  $clog2(MAX_LEN+1)  new pattern length.
- cfg_overlap  in  1  1 = overlapping matches allowed; 0 = history restarts after each match.
- count_clr  in  1  synchronous clear of match_count.
- output_detected  out  1  one-cycle match pulse, registered.
- match_count  out  CNT_W  number of matches, saturating at all-ones.
- busy_fill  out  1  high while fewer than len valid bits have been received since the last restart.

## Operation
- Internal state:
  - history shift register, MAX_LEN bits. On each valid bit: history <= {history[MAX_LEN-2:0], input_bit}.
  - fill counter, 0..len, saturating at len.
  - active pattern, length and overlap registers.
- Match condition, evaluated on the cycle a valid bit is accepted: the shifted-in history masked to its low len bits equals pattern[len-1:0], and fill+1 ≥ len.
- On match:
  - output_detected = 1 on the next cycle.
  - match_count increments, but holds once it reaches 2^CNT_W-1.
  - If overlap is 0, fill resets to 0 so the next match needs len fresh bits.
  - If overlap is 1, fill stays at len.
- Length clamping on load: cfg_len of 0 or 1 loads as 1; cfg_len > MAX_LEN loads as MAX_LEN.
- cfg_load:
  - Active pattern, length and overlap take the cfg values at the edge.
  - History and fill clear to 0.
  - Any in_valid bit in the same cycle is discarded.
  - match_count is untouched.
- count_clr clears match_count. If a match increments the counter in the same cycle, the clear wins and the count is 0.
- in_valid low: no shift, no fill change, output_detected goes low next cycle.
- Reset values:
  - output_detected = 0, match_count = 0, busy_fill = 1.
  - history = 0, fill = 0.
  - pattern = RST_PATTERN, len = RST_LEN, overlap = 1.

## Timing
- Latency: the edge that accepts the final pattern bit registers the match, so output_detected is high in the following cycle, for exactly one cycle per match.
- Back-to-back matches with overlap=1 (e.g. pattern 11, input 1,1,1) give pulses on consecutive valid cycles.
- match_count updates on the same edge as output_detected and is visible together with the pulse.
- Priority, highest first: reset > cfg_load > valid-bit processing. count_clr is independent of cfg_load.
- Reset asserted mid-stream: the next cycle shows output_detected = 0 and the reset configuration. Partial history is lost.
- busy_fill is a registered output, equal to (fill < len).

## Structure
- Package seq_detect_pkg holds:
  - the reset pattern constant (4'b1010) and its length;
  - the length-width function (clog2 of MAX_LEN+1);
  - the length-clamping function.
- Sub-module sat_counter (width CNT_W; inc, clr, saturating) implements match_count.
- The detector core is a single clocked process with combinational match-compare logic.

## Test plan
- After reset, input 1,0,1,0 with in_valid=1 every cycle → one output_detected pulse in the cycle after the 4th bit; match_count = 1.
- Reset config, overlap=1, input 1,0,1,0,1,0 → pulses after bits 4 and 6; match_count = 2.
- Load pattern 3'b110, len 3, overlap=0, then input 1,1,0,1,1,0,1,0 → pulses after bits 3 and 6 only.
- Overlap=0 versus overlap=1 with pattern 2'b11 and input 1,1,1,1 → 2 pulses versus 3 pulses.
- Pattern 1010, with the bits interleaved with in_valid=0 gaps and garbage on input_bit during the gaps → exactly one pulse, one cycle after the last valid bit.
- Boundaries, each checked separately:
  - CNT_W=2 with 5 matches → match_count holds at 3.
  - count_clr in the same cycle as a match → count = 0.
  - cfg_load after 3 of 4 bits, followed by the 4th bit → no pulse.
  - reset after 3 bits → no pulse, all outputs at reset values.
  - cfg_len = 0 → length 1 is used.
